bus_decoder_nslave: RTL

- Single-master, N-slave bus interconnect for the simulation SoC; replaces the point-to-point CPU↔memory hookup so peripherals can sit beside RAM.
- Registers each master request, decodes its address against per-slave power-of-two regions, and forwards a strobe to exactly one slave.
- Returns the slave's read data and done to the master.
- Adds unmapped-address error responses and a watchdog timeout for slaves that never complete.

---
 rtl/bus_decoder_nslave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bus_decoder_nslave.sv
// Single-master, N-slave bus decoder: registers each request, decodes it onto
// one power-of-two slave region, and returns data, done and error to the master.
module bus_decoder_nslave #(
    parameter int                        NUM_SLAVES  = 4,
    parameter int                        DATA_W      = 32,
    parameter logic [32*NUM_SLAVES-1:0]  BASE_ADDRS  = {32'h3000_0000, 32'h2000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
    parameter logic [8*NUM_SLAVES-1:0]   REGION_BITS = {8'd4, 8'd4, 8'd4, 8'd13},
    parameter int                        TIMEOUT     = 255,
    parameter logic [DATA_W-1:0]         ERR_DATA    = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    input  logic [DATA_W/8-1:0]           m_wmask,
    input  logic                          m_wen,
    input  logic                          m_ren,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_done,
    output logic                          m_err,
    output logic [31:0]                   s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wmask,
    output logic [NUM_SLAVES-1:0]         s_wen,
    output logic [NUM_SLAVES-1:0]         s_ren,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]         s_done
);

    localparam int MASK_W = DATA_W / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [DATA_W-1:0]      cap_q;
    logic [DATA_W-1:0]      m_rdata_q;
    logic                   m_done_q;
    logic                   m_err_q;
    logic [31:0]            s_addr_q;
    logic [DATA_W-1:0]      s_wdata_q;
    logic [MASK_W-1:0]      s_wmask_q;
    logic [NUM_SLAVES-1:0]  s_wen_q;
    logic [NUM_SLAVES-1:0]  s_ren_q;

    logic                   hit_c;
    logic [SEL_W-1:0]       sel_c;
    logic [NUM_SLAVES-1:0]  onehot_c;
    logic                   done_sel_c;
    logic [DATA_W-1:0]      rdata_sel_c;

    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [7:0]  rbits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << rbits;
        return ((addr ^ base) & mask) == 32'h0;
    endfunction

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        hit_c = 1'b0;
        sel_c = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (region_hit(m_addr, BASE_ADDRS[32*i +: 32], REGION_BITS[8*i +: 8])) begin
                hit_c = 1'b1;
                sel_c = SEL_W'(i);
            end
        end
    end

    assign onehot_c = NUM_SLAVES'(1) << sel_c;

    always_comb begin
        done_sel_c  = 1'b0;
        rdata_sel_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                done_sel_c  = s_done[i];
                rdata_sel_c = s_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            cap_q     <= '0;
            m_rdata_q <= '0;
            m_done_q  <= 1'b0;
            m_err_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wmask_q <= '0;
            s_wen_q   <= '0;
            s_ren_q   <= '0;
        end else begin
            s_wen_q  <= '0;
            s_ren_q  <= '0;
            m_done_q <= 1'b0;
            m_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_wen || m_ren) begin
                        s_addr_q  <= m_addr;
                        s_wdata_q <= m_wdata;
                        s_wmask_q <= m_wmask;
                        sel_q     <= sel_c;
                        if (!hit_c || (m_wen && m_ren)) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            s_wen_q <= m_wen ? onehot_c : '0;
                            s_ren_q <= m_ren ? onehot_c : '0;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    // A slave may answer in the same cycle as its strobe.
                    if (done_sel_c) begin
                        cap_q   <= rdata_sel_c;
                        state_q <= RESP;
                    end else if (TIMEOUT == 1) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (done_sel_c) begin
                        cap_q   <= rdata_sel_c;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (TIMEOUT > 1 && cnt_d == CNT_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    m_done_q  <= 1'b1;
                    m_err_q   <= err_q;
                    m_rdata_q <= err_q ? ERR_DATA : cap_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_done  = m_done_q;
    assign m_err   = m_err_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wmask = s_wmask_q;
    assign s_wen   = s_wen_q;
    assign s_ren   = s_ren_q;

endmodule
